// File: rtl/syndcnt_pkg.sv
// Shared parameter range checks and terminal-count helper for syndcnt_n and its cascades.
// Pure elaboration-time helpers; no state, no timing.
package syndcnt_pkg;

    localparam int MAX_WIDTH = 16;

    function automatic bit width_ok(input int width);
        return (width >= 1) && (width <= MAX_WIDTH);
    endfunction

    // Only meaningful once width_ok() holds, so the shift cannot overflow.
    function automatic bit modulus_ok(input int width, input int modulus);
        return (modulus >= 2) && (modulus <= (1 << width));
    endfunction

    function automatic logic [MAX_WIDTH-1:0] terminal_val(input logic up, input int modulus);
        return up ? MAX_WIDTH'(modulus - 1) : '0;
    endfunction

endpackage

// File: rtl/syn_edge.sv
// Rising-edge detector: registers din, then flags a 0->1 between consecutive samples.
// Strobe is valid the cycle after din is first sampled high; history resets to 1.
module syn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic cur;
    logic prev;

    // Both stages reset high so a strobe input already high at release never counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur  <= 1'b1;
            prev <= 1'b1;
        end else begin
            cur  <= din;
            prev <= cur;
        end
    end

    assign rise = cur & ~prev;

endmodule

// File: rtl/syndcnt_n.sv
// Modulo-N up/down counter stepped by CLK rising edges sampled on MasterClock, with sync clear/load.
// Q moves one MasterClock edge after CLK is sampled high; CO is combinational for ripple cascading.
module syndcnt_n
    import syndcnt_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2**WIDTH,
    parameter bit DOWN_EN = 1'b1
) (
    input  logic             MasterClock,
    input  logic             RESETL,
    input  logic             CLK,
    input  logic             CLL,
    input  logic             LDL,
    input  logic [WIDTH-1:0] D,
    input  logic             UP,
    input  logic             CI,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QB,
    output logic             CO
);

    generate
        if (!width_ok(WIDTH) || !modulus_ok(WIDTH, MODULUS)) begin : g_bad_params
            $error("syndcnt_n: WIDTH or MODULUS out of range");
        end
    endgenerate

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

    logic             count_stb;
    logic             up_eff;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;

    assign up_eff = DOWN_EN ? UP : 1'b1;

    syn_edge u_edge (
        .clk   (MasterClock),
        .rst_n (RESETL),
        .din   (CLK),
        .rise  (count_stb)
    );

    // Clear and load win over a same-cycle strobe; the count is dropped, not deferred.
    always_comb begin
        q_nxt = q_r;
        if (!CLL) begin
            q_nxt = '0;
        end else if (!LDL) begin
            q_nxt = (32'(D) >= MODULUS) ? TOP : D;
        end else if (count_stb && CI) begin
            if (up_eff) begin
                q_nxt = (q_r == TOP) ? '0 : q_r + WIDTH'(1);
            end else begin
                q_nxt = (q_r == '0) ? TOP : q_r - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge MasterClock or negedge RESETL) begin
        if (!RESETL) begin
            q_r <= '0;
        end else begin
            q_r <= q_nxt;
        end
    end

    assign Q  = q_r;
    assign QB = ~q_r;
    assign CO = CI & (MAX_WIDTH'(q_r) == terminal_val(up_eff, MODULUS));

endmodule
